// File: rtl/llsc_resv_ctrl.sv
// LL/SC reservation controller: tracks the reserved word, drives the LLbit
// register through a WB-aligned pending write and resolves SC in MEM.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   stall, flush        MEM/WB stall, exception/ERET flush
//   ll_valid, sc_valid  LL / SC in MEM, mem_addr their effective address
//   st_valid, st_addr   committing store (own or snooped)
//   llbit_q             LLbit register output
//   llbit_we/_wdata     LLbit register write port
//   sc_success          SC outcome for MEM
//   resv_valid/_addr    reservation state for observability
module llsc_resv_ctrl #(
   parameter int ADDR_W    = 32,
   parameter int TIMEOUT_W = 8,
   parameter int TIMEOUT   = 200
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              flush,
   input  logic              ll_valid,
   input  logic              sc_valid,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic              st_valid,
   input  logic [ADDR_W-1:0] st_addr,
   input  logic              llbit_q,
   output logic              llbit_we,
   output logic              llbit_wdata,
   output logic              sc_success,
   output logic              resv_valid,
   output logic [ADDR_W-1:0] resv_addr
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RESV = 1'b1
   } state_t;

   localparam bit                 L_TO_EN   = (TIMEOUT != 0);
   localparam logic [TIMEOUT_W-1:0] L_TO_LAST = TIMEOUT_W'(TIMEOUT - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic [TIMEOUT_W-1:0] r_age;
   logic [TIMEOUT_W-1:0] w_age_nxt;
   logic                r_pend_we;
   logic                r_pend_val;
   logic                w_sched_we;
   logic                w_sched_val;

   logic w_eff;
   logic w_mem_match;
   logic w_st_match;
   logic w_timeout;
   logic w_unused_lsb;

   // Pending value is newer than the register: forward it to hide the WB delay
   assign w_eff        = r_pend_we ? r_pend_val : llbit_q;
   assign w_mem_match  = (mem_addr[ADDR_W-1:2] == r_addr[ADDR_W-1:2]);
   assign w_st_match   = (st_addr[ADDR_W-1:2] == r_addr[ADDR_W-1:2]);
   assign w_timeout    = L_TO_EN && (r_age == L_TO_LAST);
   assign w_unused_lsb = ^{mem_addr[1:0], st_addr[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_age      <= '0;
         r_pend_we  <= 1'b0;
         r_pend_val <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_addr  <= w_addr_nxt;
         r_age   <= w_age_nxt;
         // Flush clears the LLbit even while the pipeline is stalled
         if (flush || !stall) begin
            r_pend_we  <= w_sched_we;
            r_pend_val <= w_sched_val;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_addr;
      w_age_nxt   = r_age;
      w_sched_we  = 1'b0;
      w_sched_val = 1'b0;
      if (flush) begin
         w_state_nxt = S_IDLE;
         w_age_nxt   = '0;
         w_sched_we  = 1'b1;
      end else if (!stall) begin
         unique case (r_state)
            S_IDLE: begin
               if (sc_valid) begin
                  w_sched_we = 1'b1;
               end else if (ll_valid) begin
                  w_state_nxt = S_RESV;
                  w_addr_nxt  = {mem_addr[ADDR_W-1:2], 2'b00};
                  w_age_nxt   = '0;
                  w_sched_we  = 1'b1;
                  w_sched_val = 1'b1;
               end
            end
            S_RESV: begin
               if (sc_valid || (w_timeout && !(st_valid && w_st_match && ll_valid))
                   || (st_valid && w_st_match && !ll_valid)) begin
                  w_state_nxt = S_IDLE;
                  w_age_nxt   = '0;
                  w_sched_we  = 1'b1;
               end else if (ll_valid) begin
                  // Also covers a matching store in the same cycle: LL wins
                  w_addr_nxt  = {mem_addr[ADDR_W-1:2], 2'b00};
                  w_age_nxt   = '0;
                  w_sched_we  = 1'b1;
                  w_sched_val = 1'b1;
               end else if (!(&r_age)) begin
                  w_age_nxt = r_age + TIMEOUT_W'(1);
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_comb begin
      sc_success  = sc_valid && !flush && (r_state == S_RESV)
                    && w_eff && w_mem_match;
      llbit_we    = r_pend_we;
      llbit_wdata = r_pend_val;
      resv_valid  = (r_state == S_RESV);
      resv_addr   = r_addr;
   end

endmodule

// File: tb/tb_llsc_resv_ctrl.sv
// Bench for llsc_resv_ctrl: table-driven cycle vectors with a scoreboard,
// plus a hand-written asynchronous reset sequence.
module tb_llsc_resv_ctrl;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        flush;
   logic        ll_valid;
   logic        sc_valid;
   logic [31:0] mem_addr;
   logic        st_valid;
   logic [31:0] st_addr;
   logic        llbit_q;
   logic        llbit_we;
   logic        llbit_wdata;
   logic        sc_success;
   logic        resv_valid;
   logic [31:0] resv_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        stall;
      logic        flush;
      logic        ll;
      logic        sc;
      logic        st;
      logic [31:0] ma;
      logic [31:0] sa;
      logic        e_sc;
      logic        e_rv;
      logic        e_we;
      logic        e_wd;
      logic [31:0] e_ra;
   } vec_t;

   vec_t tab1[$];
   vec_t tab2[$];
   vec_t exp_q[$];

   llsc_resv_ctrl #(
      .ADDR_W   (32),
      .TIMEOUT_W(8),
      .TIMEOUT  (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .stall      (stall),
      .flush      (flush),
      .ll_valid   (ll_valid),
      .sc_valid   (sc_valid),
      .mem_addr   (mem_addr),
      .st_valid   (st_valid),
      .st_addr    (st_addr),
      .llbit_q    (llbit_q),
      .llbit_we   (llbit_we),
      .llbit_wdata(llbit_wdata),
      .sc_success (sc_success),
      .resv_valid (resv_valid),
      .resv_addr  (resv_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural LLbit register fed by the DUT write port
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) llbit_q <= 1'b0;
      else if (llbit_we) llbit_q <= llbit_wdata;
   end

   function automatic vec_t mk(
      input logic s, input logic f, input logic l, input logic c, input logic t,
      input logic [31:0] ma, input logic [31:0] sa,
      input logic esc, input logic erv, input logic ewe, input logic ewd,
      input logic [31:0] era);
      vec_t v;
      v.stall = s; v.flush = f; v.ll = l; v.sc = c; v.st = t;
      v.ma = ma; v.sa = sa;
      v.e_sc = esc; v.e_rv = erv; v.e_we = ewe; v.e_wd = ewd; v.e_ra = era;
      return v;
   endfunction

   function automatic vec_t idl(input logic erv, input logic ewe,
                                input logic ewd, input logic [31:0] era);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, erv, ewe, ewd, era);
   endfunction

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", nm, idx, act, req);
      end
   endtask

   task automatic run_vec(input vec_t x, input int idx);
      vec_t e;
      @(negedge clk);
      stall    = x.stall;
      flush    = x.flush;
      ll_valid = x.ll;
      sc_valid = x.sc;
      st_valid = x.st;
      mem_addr = x.ma;
      st_addr  = x.sa;
      exp_q.push_back(x);
      #2;
      e = exp_q.pop_front();
      chk("sc_success", idx, 32'(sc_success), 32'(e.e_sc));
      chk("resv_valid", idx, 32'(resv_valid), 32'(e.e_rv));
      chk("llbit_we", idx, 32'(llbit_we), 32'(e.e_we));
      chk("llbit_wdata", idx, 32'(llbit_wdata), 32'(e.e_wd));
      chk("resv_addr", idx, resv_addr, e.e_ra);
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_sc"}, 0, 32'(sc_success), 0);
      chk({nm, "_rv"}, 0, 32'(resv_valid), 0);
      chk({nm, "_we"}, 0, 32'(llbit_we), 0);
      chk({nm, "_wd"}, 0, 32'(llbit_wdata), 0);
      chk({nm, "_ra"}, 0, resv_addr, 0);
   endtask

   initial begin
      rst_n = 1'b0; stall = 0; flush = 0; ll_valid = 0; sc_valid = 0;
      st_valid = 0; mem_addr = '0; st_addr = '0;

      // LL, idle x3, SC at last age before expiry
      tab1.push_back(mk(0,0,1,0,0,'h1000,0, 0,0,0,0,'h0));
      tab1.push_back(idl(1,1,1,'h1000));
      tab1.push_back(idl(1,0,0,'h1000));
      tab1.push_back(idl(1,0,0,'h1000));
      tab1.push_back(mk(0,0,0,1,0,'h1000,0, 1,1,0,0,'h1000));
      tab1.push_back(idl(0,1,0,'h1000));
      tab1.push_back(idl(0,0,0,'h1000));
      // forwarding: SC right after LL
      tab1.push_back(mk(0,0,1,0,0,'h1000,0, 0,0,0,0,'h1000));
      tab1.push_back(mk(0,0,0,1,0,'h1000,0, 1,1,1,1,'h1000));
      tab1.push_back(idl(0,1,0,'h1000));
      tab1.push_back(idl(0,0,0,'h1000));
      // conflicting store to same word
      tab1.push_back(mk(0,0,1,0,0,'h2000,0, 0,0,0,0,'h1000));
      tab1.push_back(mk(0,0,0,0,1,0,'h2002, 0,1,1,1,'h2000));
      tab1.push_back(mk(0,0,0,1,0,'h2000,0, 0,0,1,0,'h2000));
      tab1.push_back(idl(0,1,0,'h2000));
      tab1.push_back(idl(0,0,0,'h2000));
      // flush kills reservation
      tab1.push_back(mk(0,0,1,0,0,'h3000,0, 0,0,0,0,'h2000));
      tab1.push_back(mk(0,1,0,0,0,0,0, 0,1,1,1,'h3000));
      tab1.push_back(mk(0,0,0,1,0,'h3000,0, 0,0,1,0,'h3000));
      tab1.push_back(idl(0,1,0,'h3000));
      tab1.push_back(idl(0,0,0,'h3000));
      // timeout after 4 cycles, 5-cycle wait
      tab1.push_back(mk(0,0,1,0,0,'h4000,0, 0,0,0,0,'h3000));
      tab1.push_back(idl(1,1,1,'h4000));
      tab1.push_back(idl(1,0,0,'h4000));
      tab1.push_back(idl(1,0,0,'h4000));
      tab1.push_back(idl(1,0,0,'h4000));
      tab1.push_back(idl(0,1,0,'h4000));
      tab1.push_back(mk(0,0,0,1,0,'h4000,0, 0,0,0,0,'h4000));
      tab1.push_back(idl(0,1,0,'h4000));
      tab1.push_back(idl(0,0,0,'h4000));
      // 2-cycle wait succeeds
      tab1.push_back(mk(0,0,1,0,0,'h4000,0, 0,0,0,0,'h4000));
      tab1.push_back(idl(1,1,1,'h4000));
      tab1.push_back(idl(1,0,0,'h4000));
      tab1.push_back(mk(0,0,0,1,0,'h4000,0, 1,1,0,0,'h4000));
      tab1.push_back(idl(0,1,0,'h4000));
      tab1.push_back(idl(0,0,0,'h4000));
      // LL held by stall, then released
      tab1.push_back(mk(1,0,1,0,0,'h5000,0, 0,0,0,0,'h4000));
      tab1.push_back(mk(1,0,1,0,0,'h5000,0, 0,0,0,0,'h4000));
      tab1.push_back(mk(1,0,1,0,0,'h5000,0, 0,0,0,0,'h4000));
      tab1.push_back(mk(0,0,1,0,0,'h5000,0, 0,0,0,0,'h4000));
      tab1.push_back(idl(1,1,1,'h5000));

      // SC and store same word, same cycle
      tab2.push_back(mk(0,0,1,0,0,'h6000,0, 0,0,0,0,'h0));
      tab2.push_back(mk(0,0,0,1,1,'h6000,'h6000, 1,1,1,1,'h6000));
      tab2.push_back(idl(0,1,0,'h6000));
      tab2.push_back(idl(0,0,0,'h6000));
      // store match + LL: LL wins; stall holds pending; flush under stall
      tab2.push_back(mk(0,0,1,0,0,'h7000,0, 0,0,0,0,'h6000));
      tab2.push_back(mk(0,0,1,0,1,'h7100,'h7001, 0,1,1,1,'h7000));
      tab2.push_back(mk(1,0,0,0,0,0,0, 0,1,1,1,'h7100));
      tab2.push_back(mk(1,0,0,0,0,0,0, 0,1,1,1,'h7100));
      tab2.push_back(mk(0,0,0,0,1,0,'h7000, 0,1,1,1,'h7100));
      tab2.push_back(mk(1,1,0,0,0,0,0, 0,1,0,0,'h7100));
      tab2.push_back(mk(0,0,0,1,0,'h7100,0, 0,0,1,0,'h7100));
      tab2.push_back(idl(0,1,0,'h7100));
      tab2.push_back(idl(0,0,0,'h7100));

      #1;
      chk_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (tab1[i]) run_vec(tab1[i], i);

      // asynchronous reset while a reservation is held
      @(negedge clk);
      chk("pre_reset_rv", 0, 32'(resv_valid), 1);
      #1 rst_n = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tab2[i]) run_vec(tab2[i], 100 + i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
